// File: rtl/mips_pkg.sv
// Shared constants and types for the single-cycle MIPS subset core:
// opcode/funct encodings, ALU operation set and decoded control bundle.
package mips_pkg;

  localparam int NUM_REGS   = 32;
  localparam int IMEM_DEPTH = 64;
  localparam int DMEM_DEPTH = 64;
  localparam int PC_W       = $clog2(IMEM_DEPTH);
  localparam int DADDR_W    = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

  typedef struct packed {
    logic reg_write;
    logic reg_dst;
    logic alu_src;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic branch_ne;
    logic jump;
    logic link;
    logic jr;
    logic imm_zext;
  } ctrl_t;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic zext);
    return zext ? {16'd0, imm} : {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file, two combinational read ports and one write port at the clock edge.
// $0 is hardwired to zero; the whole file clears asynchronously on reset.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [4:0]  i_raddr_a,
  input  logic [4:0]  i_raddr_b,
  output logic [31:0] o_rdata_a,
  output logic [31:0] o_rdata_b,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign o_rdata_a = (i_raddr_a == 5'd0) ? 32'd0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == 5'd0) ? 32'd0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mips_sc_cpu.sv
// Single-cycle MIPS subset core: one instruction committed per clock,
// combinational decode/ALU/memory access, PC/register/memory writes on the same edge.
module mips_sc_cpu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [5:0]  iaddr,
  input  logic [31:0] idata,
  output logic [5:0]  daddr,
  output logic        dwr,
  output logic [31:0] ddout,
  input  logic [31:0] ddin
);

  logic [PC_W-1:0] r_pc;

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_sh;
  logic [15:0] w_imm;

  assign w_op  = idata[31:26];
  assign w_rs  = idata[25:21];
  assign w_rt  = idata[20:16];
  assign w_rd  = idata[15:11];
  assign w_sh  = idata[10:6];
  assign w_fn  = idata[5:0];
  assign w_imm = idata[15:0];

  ctrl_t   w_ctrl;
  alu_op_t w_alu_op;

  always_comb begin
    w_ctrl   = '0;
    w_alu_op = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
        case (w_fn)
          FN_ADD, FN_ADDU: w_alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: w_alu_op = ALU_SUB;
          FN_AND:          w_alu_op = ALU_AND;
          FN_OR:           w_alu_op = ALU_OR;
          FN_XOR:          w_alu_op = ALU_XOR;
          FN_NOR:          w_alu_op = ALU_NOR;
          FN_SLT:          w_alu_op = ALU_SLT;
          FN_SLTU:         w_alu_op = ALU_SLTU;
          FN_SLL:          w_alu_op = ALU_SLL;
          FN_SRL:          w_alu_op = ALU_SRL;
          FN_SRA:          w_alu_op = ALU_SRA;
          FN_JR: begin
            w_ctrl    = '0;
            w_ctrl.jr = 1'b1;
          end
          default:         w_ctrl = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OP_SLTI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_alu_op         = ALU_SLT;
      end
      OP_SLTIU: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_alu_op         = ALU_SLTU;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.imm_zext  = 1'b1;
        w_alu_op = (w_op == OP_ANDI) ? ALU_AND : (w_op == OP_ORI) ? ALU_OR : ALU_XOR;
      end
      OP_LUI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_alu_op         = ALU_LUI;
      end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: w_ctrl.branch = 1'b1;
      OP_BNE: begin
        w_ctrl.branch    = 1'b1;
        w_ctrl.branch_ne = 1'b1;
      end
      OP_J:   w_ctrl.jump = 1'b1;
      OP_JAL: begin
        w_ctrl.jump      = 1'b1;
        w_ctrl.link      = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  logic [31:0] w_rs_val, w_rt_val;
  logic        w_we;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;

  mips_regfile u_regfile (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_val),
    .o_rdata_b (w_rt_val),
    .i_we      (w_we),
    .i_waddr   (w_wr_addr),
    .i_wdata   (w_wr_data)
  );

  logic [31:0] w_imm_ext, w_alu_b, w_alu_res;

  assign w_imm_ext = ext_imm(w_imm, w_ctrl.imm_zext);
  assign w_alu_b   = w_ctrl.alu_src ? w_imm_ext : w_rt_val;

  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD:  w_alu_res = w_rs_val + w_alu_b;
      ALU_SUB:  w_alu_res = w_rs_val - w_alu_b;
      ALU_AND:  w_alu_res = w_rs_val & w_alu_b;
      ALU_OR:   w_alu_res = w_rs_val | w_alu_b;
      ALU_XOR:  w_alu_res = w_rs_val ^ w_alu_b;
      ALU_NOR:  w_alu_res = ~(w_rs_val | w_alu_b);
      ALU_SLT:  w_alu_res = {31'd0, $signed(w_rs_val) < $signed(w_alu_b)};
      ALU_SLTU: w_alu_res = {31'd0, w_rs_val < w_alu_b};
      ALU_SLL:  w_alu_res = w_alu_b << w_sh;
      ALU_SRL:  w_alu_res = w_alu_b >> w_sh;
      ALU_SRA:  w_alu_res = $signed(w_alu_b) >>> w_sh;
      ALU_LUI:  w_alu_res = {w_alu_b[15:0], 16'd0};
      default:  w_alu_res = '0;
    endcase
  end

  logic [PC_W-1:0] w_pc_plus1, w_br_target, w_pc_next;
  logic            w_br_taken;

  assign w_pc_plus1  = r_pc + PC_W'(1);
  // Sign-extended offset truncated to the PC width is just its low bits.
  assign w_br_target = w_pc_plus1 + w_imm[PC_W-1:0];
  assign w_br_taken  = w_ctrl.branch & ((w_rs_val == w_rt_val) ^ w_ctrl.branch_ne);

  always_comb begin
    w_pc_next = w_pc_plus1;
    if (w_ctrl.jr)        w_pc_next = w_rs_val[PC_W+1:2];
    else if (w_ctrl.jump) w_pc_next = idata[PC_W-1:0];
    else if (w_br_taken)  w_pc_next = w_br_target;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= '0;
    else      r_pc <= w_pc_next;
  end

  assign w_we      = w_ctrl.reg_write;
  assign w_wr_addr = w_ctrl.link ? 5'd31 : (w_ctrl.reg_dst ? w_rd : w_rt);
  assign w_wr_data = w_ctrl.link       ? {{(32-PC_W){1'b0}}, w_pc_plus1} :
                     w_ctrl.mem_to_reg ? ddin : w_alu_res;

  assign iaddr = r_pc;
  assign daddr = w_alu_res[DADDR_W+1:2];
  assign ddout = w_rt_val;
  // Store enable is gated by reset so an interrupted sw never reaches memory.
  assign dwr   = w_ctrl.mem_write & rst;

endmodule

// File: tb/tb_mips_sc_cpu.sv
// Bench for mips_sc_cpu: ISA-level reference interpreter plus bench-owned instruction/data memories.
module tb_mips_sc_cpu;

  logic        clk, rst;
  logic [5:0]  iaddr, daddr;
  logic [31:0] idata, ddout, ddin;
  logic        dwr;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic        dmem_fill;

  logic [5:0]  m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [64];

  int n_tests = 0;
  int n_fail  = 0;

  logic        obs_dwr;
  logic [5:0]  obs_iaddr, obs_daddr;
  logic [31:0] obs_ddout;

  mips_sc_cpu dut (
    .clk   (clk),
    .rst   (rst),
    .iaddr (iaddr),
    .idata (idata),
    .daddr (daddr),
    .dwr   (dwr),
    .ddout (ddout),
    .ddin  (ddin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign idata = imem[iaddr];
  assign ddin  = dmem[daddr];

  always @(posedge clk) begin
    if (dmem_fill) begin
      for (int i = 0; i < 64; i++) dmem[i] <= $urandom;
    end else if (dwr) begin
      dmem[daddr] <= ddout;
    end
  end

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs,
                                        input int rt, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs,
                                        input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fns [15];
    logic [5:0] ops [20];
    int rs, rt, rd;
    fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h3F};
    ops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B,
            6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F, 6'h10, 6'h2B, 6'h09};
    rs = $urandom_range(0, 7);
    rt = $urandom_range(0, 7);
    rd = ($urandom_range(0, 9) == 0) ? 31 : $urandom_range(0, 7);
    if ($urandom_range(0, 2) == 0)
      return enc_r(fns[$urandom_range(0, 14)], rd, rs, rt, $urandom_range(0, 31));
    return enc_i(ops[$urandom_range(0, 19)], rt, rs, $urandom);
  endfunction

  // Architectural interpreter: executes imem[m_pc] and reports the expected store, if any.
  task automatic model_step(output logic e_dwr, output logic [5:0] e_daddr, output logic [31:0] e_dout);
    logic [31:0] ins, a, b, se, ze, wd, ea;
    logic [5:0]  op, fn, npc;
    logic [4:0]  rs, rt, rd, sh, wa;
    logic        wr;
    ins = imem[m_pc];
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    a  = m_regs[rs]; b = m_regs[rt];
    se = {{16{ins[15]}}, ins[15:0]};
    ze = {16'd0, ins[15:0]};
    ea = a + se;
    npc = m_pc + 6'd1;
    wr = 1'b0; wa = rt; wd = '0;
    e_dwr = 1'b0; e_daddr = '0; e_dout = '0;
    case (op)
      6'h00: begin
        wa = rd; wr = 1'b1;
        case (fn)
          6'h20, 6'h21: wd = a + b;
          6'h22, 6'h23: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h26: wd = a ^ b;
          6'h27: wd = ~(a | b);
          6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: wd = (a < b) ? 32'd1 : 32'd0;
          6'h00: wd = b << sh;
          6'h02: wd = b >> sh;
          6'h03: wd = $signed(b) >>> sh;
          6'h08: begin wr = 1'b0; npc = a[7:2]; end
          default: wr = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin wr = 1'b1; wd = a + se; end
      6'h0A: begin wr = 1'b1; wd = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0B: begin wr = 1'b1; wd = (a < se) ? 32'd1 : 32'd0; end
      6'h0C: begin wr = 1'b1; wd = a & ze; end
      6'h0D: begin wr = 1'b1; wd = a | ze; end
      6'h0E: begin wr = 1'b1; wd = a ^ ze; end
      6'h0F: begin wr = 1'b1; wd = {ins[15:0], 16'd0}; end
      6'h23: begin wr = 1'b1; wd = m_dmem[ea[7:2]]; end
      6'h2B: begin
        e_dwr = 1'b1; e_daddr = ea[7:2]; e_dout = b;
        m_dmem[ea[7:2]] = b;
      end
      6'h04: if (a == b) npc = m_pc + 6'd1 + se[5:0];
      6'h05: if (a != b) npc = m_pc + 6'd1 + se[5:0];
      6'h02: npc = ins[5:0];
      6'h03: begin npc = ins[5:0]; wr = 1'b1; wa = 5'd31; wd = {26'd0, 6'(m_pc + 6'd1)}; end
      default: ;
    endcase
    if (wr && wa != 5'd0) m_regs[wa] = wd;
    m_pc = npc;
  endtask

  task automatic model_reset();
    m_pc = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 64; i++) m_dmem[i] = dmem[i];
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = '0;
  endtask

  task automatic load_dump();
    for (int i = 0; i < 64; i++) imem[i] = enc_i(6'h2B, i % 32, 0, 4 * (i % 32));
  endtask

  // Called at a falling edge; compares the pre-edge outputs, then advances the model one instruction.
  task automatic cycle_check(input string tag);
    logic e_dwr; logic [5:0] e_da; logic [31:0] e_do;
    #1;
    obs_iaddr = iaddr; obs_dwr = dwr; obs_daddr = daddr; obs_ddout = ddout;
    n_tests++;
    if (iaddr !== m_pc) begin
      n_fail++; $display("FAIL %s iaddr got %0d expected %0d", tag, iaddr, m_pc);
    end
    model_step(e_dwr, e_da, e_do);
    n_tests++;
    if (dwr !== e_dwr) begin
      n_fail++; $display("FAIL %s dwr at pc %0d got %0b expected %0b", tag, obs_iaddr, dwr, e_dwr);
    end
    if (e_dwr) begin
      n_tests++;
      if (daddr !== e_da) begin
        n_fail++; $display("FAIL %s daddr at pc %0d got %0d expected %0d", tag, obs_iaddr, daddr, e_da);
      end
      n_tests++;
      if (ddout !== e_do) begin
        n_fail++; $display("FAIL %s ddout at pc %0d got %h expected %h", tag, obs_iaddr, ddout, e_do);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    dmem_fill = 1'b1;
    @(negedge clk);
    dmem_fill = 1'b0;
    @(negedge clk);
    clear_imem();
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    imem[0] = enc_i(6'h2B, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (iaddr !== 6'd0) begin n_fail++; $display("FAIL reset_iaddr got %0d expected 0", iaddr); end
      n_tests++;
      if (dwr !== 1'b0) begin n_fail++; $display("FAIL reset_dwr got %0b expected 0", dwr); end
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle_check("reset_step");
      n_tests++;
      if (obs_iaddr !== 6'(k)) begin
        n_fail++; $display("FAIL reset_pc_step got %0d expected %0d", obs_iaddr, k);
      end
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp_v [4];
    exp_v = '{32'd2, 32'd1, 32'd0, 32'hFFFF_FFFE};
    do_reset();
    imem[0] = enc_i(6'h08, 1, 0, 5);
    imem[1] = enc_i(6'h08, 2, 0, -3);
    imem[2] = enc_r(6'h20, 3, 1, 2, 0);
    imem[3] = enc_r(6'h2A, 4, 2, 1, 0);
    imem[4] = enc_r(6'h2B, 5, 2, 1, 0);
    imem[5] = enc_r(6'h03, 6, 0, 2, 1);
    imem[6] = enc_i(6'h2B, 3, 0, 0);
    imem[7] = enc_i(6'h2B, 4, 0, 4);
    imem[8] = enc_i(6'h2B, 5, 0, 8);
    imem[9] = enc_i(6'h2B, 6, 0, 12);
    for (int i = 0; i < 6; i++) cycle_check("alu");
    for (int i = 0; i < 4; i++) begin
      cycle_check("alu_store");
      n_tests++;
      if (obs_ddout !== exp_v[i]) begin
        n_fail++; $display("FAIL alu_result%0d got %h expected %h", i, obs_ddout, exp_v[i]);
      end
    end
  endtask

  task automatic test_mem();
    do_reset();
    imem[0] = enc_i(6'h08, 1, 0, 32'h1234);
    imem[1] = enc_i(6'h2B, 1, 0, 8);
    imem[2] = enc_i(6'h23, 2, 0, 8);
    imem[3] = enc_i(6'h2B, 2, 0, 12);
    cycle_check("mem");
    cycle_check("mem_sw");
    n_tests++;
    if (obs_dwr !== 1'b1 || obs_daddr !== 6'd2 || obs_ddout !== 32'h1234) begin
      n_fail++;
      $display("FAIL mem_sw got dwr=%0b daddr=%0d ddout=%h expected 1/2/00001234", obs_dwr, obs_daddr, obs_ddout);
    end
    cycle_check("mem_lw");
    cycle_check("mem_sw2");
    n_tests++;
    if (obs_daddr !== 6'd3 || obs_ddout !== 32'h1234) begin
      n_fail++; $display("FAIL mem_lw_value got daddr=%0d ddout=%h expected 3/00001234", obs_daddr, obs_ddout);
    end
    n_tests++;
    if (dmem[2] !== 32'h1234) begin
      n_fail++; $display("FAIL mem_written got %h expected 00001234", dmem[2]);
    end
  endtask

  task automatic test_branch_jump();
    int seq [10];
    seq = '{0, 1, 5, 4, 5, 6, 7, 10, 20, 21};
    do_reset();
    imem[0]  = enc_i(6'h08, 5, 0, 1);
    imem[1]  = {6'h02, 26'd5};
    imem[4]  = enc_i(6'h08, 1, 1, 1);
    imem[5]  = enc_i(6'h04, 0, 1, -2);
    imem[6]  = enc_i(6'h05, 5, 1, 5);
    imem[7]  = {6'h02, 26'd10};
    imem[10] = {6'h03, 26'd20};
    imem[20] = enc_i(6'h2B, 31, 0, 0);
    imem[21] = enc_i(6'h2B, 1, 0, 4);
    for (int i = 0; i < 10; i++) begin
      cycle_check("br");
      n_tests++;
      if (obs_iaddr !== 6'(seq[i])) begin
        n_fail++; $display("FAIL br_seq%0d got %0d expected %0d", i, obs_iaddr, seq[i]);
      end
    end
    n_tests++;
    if (obs_ddout !== 32'd1) begin n_fail++; $display("FAIL br_loop_count got %h expected 1", obs_ddout); end
    n_tests++;
    if (dmem[0] !== 32'd11) begin n_fail++; $display("FAIL jal_link got %h expected 0000000b", dmem[0]); end
  endtask

  task automatic test_edge();
    int seq [9];
    seq = '{0, 1, 2, 3, 4, 5, 62, 63, 0};
    do_reset();
    imem[0]  = enc_i(6'h08, 0, 0, 7);
    imem[1]  = enc_i(6'h0F, 1, 0, 32'hFFFF);
    imem[2]  = {6'h3F, 5'd0, 5'd1, 16'h0008};
    imem[3]  = enc_i(6'h2B, 0, 0, 0);
    imem[4]  = enc_i(6'h2B, 1, 0, 4);
    imem[5]  = {6'h02, 26'd62};
    imem[62] = enc_i(6'h08, 2, 0, 9);
    imem[63] = enc_i(6'h08, 3, 0, 1);
    for (int i = 0; i < 9; i++) begin
      cycle_check("edge");
      n_tests++;
      if (obs_iaddr !== 6'(seq[i])) begin
        n_fail++; $display("FAIL edge_seq%0d got %0d expected %0d", i, obs_iaddr, seq[i]);
      end
      if (i == 2) begin
        n_tests++;
        if (obs_dwr !== 1'b0) begin n_fail++; $display("FAIL illegal_dwr got %0b expected 0", obs_dwr); end
      end
      if (i == 3) begin
        n_tests++;
        if (obs_ddout !== 32'd0) begin n_fail++; $display("FAIL zero_reg got %h expected 0", obs_ddout); end
      end
      if (i == 4) begin
        n_tests++;
        if (obs_ddout !== 32'hFFFF_0000) begin
          n_fail++; $display("FAIL lui got %h expected ffff0000", obs_ddout);
        end
      end
    end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] pre;
    do_reset();
    imem[0] = enc_i(6'h08, 1, 0, 32'h55);
    imem[1] = enc_i(6'h2B, 1, 0, 16);
    cycle_check("mid");
    pre = dmem[4];
    #1;
    n_tests++;
    if (dwr !== 1'b1) begin n_fail++; $display("FAIL mid_sw_active got %0b expected 1", dwr); end
    rst = 1'b0;
    #1;
    n_tests++;
    if (dwr !== 1'b0) begin n_fail++; $display("FAIL mid_dwr_drop got %0b expected 0", dwr); end
    n_tests++;
    if (iaddr !== 6'd0) begin n_fail++; $display("FAIL mid_pc_clear got %0d expected 0", iaddr); end
    @(negedge clk);
    n_tests++;
    if (dmem[4] !== pre) begin n_fail++; $display("FAIL mid_no_write got %h expected %h", dmem[4], pre); end
    model_reset();
    load_dump();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) cycle_check("mid_dump");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 64; i++) imem[i] = rand_instr();
      for (int c = 0; c < 400; c++) cycle_check("rand");
      load_dump();
      for (int c = 0; c < 32; c++) cycle_check("rand_dump");
    end
  endtask

  initial begin
    rst = 1'b0;
    dmem_fill = 1'b0;
    clear_imem();
    for (int i = 0; i < 64; i++) dmem[i] = '0;
    model_reset();
    test_reset();
    test_alu();
    test_mem();
    test_branch_jump();
    test_edge();
    test_midrun_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_sc_cpu.md
# mips_sc_cpu

Single-cycle 32-bit MIPS subset processor core: fetches one instruction per clock from an external 64-word instruction memory and accesses an external 64-word data memory. It is the compute core of the system, instantiated next to the instruction ROM (combinational read) and the data RAM (combinational read, synchronous write).

## Interface
- No parameters. Internal constants: IMEM depth 64 words, DMEM depth 64 words, 32 registers.
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (asserted = 0).
- iaddr  output  6  instruction word address (PC word index).
- idata  input  32  instruction at iaddr, combinational from instruction memory.
- daddr  output  6  data word address = ALU result bits [7:2].
- dwr  output  1  data write enable, high only for executing sw.
- ddout  output  32  store data = register rt value.
- ddin  input  32  load data at daddr, combinational from data memory.

## Operation
- PC is a 6-bit word index; iaddr = PC. Next PC default PC+1, wraps 63→0.
- Register file: 32×32, two combinational reads (rs, rt), one write port at rising clk; writes to $0 discarded, $0 reads 0.
- Supported R-type (opcode 0, by funct): add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, sltu 0x2B, sll 0x00, srl 0x02, sra 0x03, jr 0x08. Destination rd.
- Supported I-type: addi 0x08, addiu 0x09, slti 0x0A, sltiu 0x0B, andi 0x0C, ori 0x0D, xori 0x0E, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, bne 0x05. Destination rt.
- Jump: j 0x02 → PC = instr[5:0]; jal 0x03 → same, $31 = PC+1 (word index, zero-extended); jr → PC = rs[7:2].
- Immediates: sign-extended for arithmetic, slt*, lw/sw, branches; zero-extended for andi/ori/xori; lui = imm<<16.
- Branch taken: PC = PC+1+sign-extended offset (truncated to 6 bits). No delay slot.
- Overflow ignored; add/addi behave as addu/addiu (no exception).
- lw: rt ← ddin. sw: dwr=1, daddr=(rs+imm)[7:2], ddout=rt; byte address bits [1:0] ignored.
- Any unrecognised opcode/funct executes as NOP: no register write, dwr=0, PC+1.

## Timing
- Reset (rst=0): PC=0, all 32 registers=0 immediately (asynchronous); iaddr=0; dwr=0 while rst=0 irrespective of idata.
- After rst release, first rising edge commits instruction at address 0.
- CPI = 1: decode, execute, memory and writeback combinational within one cycle; register, PC and data-memory writes all on the same rising edge.
- Load result visible to the next instruction (no hazards, no stalls).
- rst assertion mid-program aborts the current instruction: no register or memory write occurs for it.
- Reg read of the register written in the same cycle returns the old value (write completes at edge).

## Structure
- Shared package mips_pkg: opcode and funct constants, ALU operation enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI), control-signal struct (reg_write, reg_dst, alu_src, mem_write, mem_to_reg, branch, branch_ne, jump, link, jr, imm_zext).
- One sub-module: mips_regfile (32×32, 2R1W, async active-low reset). Decoder and ALU stay as combinational blocks in the top.

## Test plan
- Reset: hold rst=0 three cycles → iaddr=0, dwr=0; release, PC steps 0,1,2 each clock.
- ALU: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1; sltu $5,$2,$1 → $3=2, $4=1, $5=0.
- Memory: addi $1,$0,0x1234; sw $1,8($0); lw $2,8($0) → during sw daddr=2, dwr=1, ddout=0x00001234; $2=0x00001234.
- Branch/jump: beq taken with offset -2 loops; bne not-taken falls through; j 10 → iaddr=10; jal 20 → $31=PC+1.
- Edge cases: write to $0 keeps 0; lui $1,0xFFFF → 0xFFFF0000; PC wraps 63→0; illegal opcode 0x3F → no state change except PC+1.
- Mid-run reset: assert rst while executing sw → dwr drops immediately, no memory write, PC=0.
